// File: rtl/hwlp_if.sv
// Hardware-loop sequencer bus: decoder setup writes, ID-stage retire info and
// the PC-redirect request back to the controller.
interface hwlp_if #(
  parameter int N_HWLP_W = 1
);
  // Handshake: no ready path anywhere. A write is taken on every clk edge where a
  // hwlp_we bit is high. id_valid qualifies pc_id for exactly that cycle. hwlp_jump
  // is a same-cycle combinational request; hwlp_target is only meaningful while it is high.
  logic [2:0]          hwlp_we;
  logic [N_HWLP_W-1:0] hwlp_regid;
  logic [31:0]         hwlp_wdata;
  logic [31:0]         pc_id;
  logic                id_valid;
  logic                flush;
  logic                hwlp_jump;
  logic [31:0]         hwlp_target;

  modport master (
    output hwlp_we, hwlp_regid, hwlp_wdata, pc_id, id_valid, flush,
    input  hwlp_jump, hwlp_target
  );

  modport slave (
    input  hwlp_we, hwlp_regid, hwlp_wdata, pc_id, id_valid, flush,
    output hwlp_jump, hwlp_target
  );
endinterface

// File: rtl/hwlp_sequencer.sv
// Hardware-loop sequencer: per-loop start/end/count registers, end-of-loop PC redirect.
// Optional HWLP_SETUP_CHECK_EN adds setup_err_o, which flags malformed loop setups.
module hwlp_sequencer #(
  parameter int N_HWLP   = 2,
  parameter int N_HWLP_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hwlp_if.slave                  bus,
  output logic [N_HWLP-1:0][31:0] hwlp_start_o,
  output logic [N_HWLP-1:0][31:0] hwlp_end_o,
  output logic [N_HWLP-1:0][31:0] hwlp_cnt_o,
  output logic                   hwlp_active_o,
  output logic                   state_dbg_o
`ifdef HWLP_SETUP_CHECK_EN
  , output logic                 setup_err_o
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [N_HWLP-1:0][31:0] start_q, start_d;
  logic [N_HWLP-1:0][31:0] end_q, end_d;
  logic [N_HWLP-1:0][31:0] cnt_q, cnt_d;
  logic [0:0]              state_q, state_d;
  logic [N_HWLP-1:0]       match;
  logic                    blocked;
  logic                    jump;
  logic [31:0]             target;
  logic [N_HWLP_W-1:0]     regid;

  assign regid = bus.hwlp_regid;

  // Scan innermost first; a loop on its last pass decrements to 0 and lets the
  // next outer loop see the same PC. The first loop that jumps blocks the rest.
  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    jump    = 1'b0;
    target  = 32'h0;
    blocked = 1'b0;
    match   = '0;
    for (int i = 0; i < N_HWLP; i++) begin
      match[i] = bus.id_valid & ~bus.flush & (bus.pc_id == end_q[i]) & (cnt_q[i] != 32'd0);
      if (match[i] && !blocked) begin
        cnt_d[i] = cnt_q[i] - 32'd1;
        if (cnt_q[i] > 32'd1) begin
          jump    = 1'b1;
          target  = start_q[i];
          blocked = 1'b1;
        end
      end
      // Writes come after the decrement so a cnt write overrides it
      if (int'(regid) == i) begin
        if (bus.hwlp_we[0]) start_d[i] = {bus.hwlp_wdata[31:1], 1'b0};
        if (bus.hwlp_we[1]) end_d[i]   = {bus.hwlp_wdata[31:1], 1'b0};
        if (bus.hwlp_we[2]) cnt_d[i]   = bus.hwlp_wdata;
      end
    end
    state_d = (cnt_d != '0) ? ST_ARMED : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      start_q <= start_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign bus.hwlp_jump   = jump;
  assign bus.hwlp_target = target;
  assign hwlp_start_o    = start_q;
  assign hwlp_end_o      = end_q;
  assign hwlp_cnt_o      = cnt_q;
  assign hwlp_active_o   = (state_q == ST_ARMED);
  assign state_dbg_o     = state_q;

`ifdef HWLP_SETUP_CHECK_EN
  logic setup_err_q, setup_err_d;

  // Judged on the post-write values, so multi-hot setups are checked as a whole
  always_comb begin
    setup_err_d = 1'b0;
    if (bus.hwlp_we[2] && (bus.hwlp_wdata != 32'd0) && (end_d[regid] <= start_d[regid]))
      setup_err_d = 1'b1;
    if (bus.hwlp_we[1:0] != 2'b00) begin
      for (int i = 0; i < N_HWLP - 1; i++) begin
        if ((cnt_d[i] != 32'd0) && (cnt_d[i+1] != 32'd0) &&
            !((start_d[i+1] <= start_d[i]) && (end_d[i] <= end_d[i+1])))
          setup_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) setup_err_q <= 1'b0;
    else        setup_err_q <= setup_err_d;
  end

  assign setup_err_o = setup_err_q;
`endif

endmodule

// File: tb/tb_hwlp_sequencer.sv
// Bench for hwlp_sequencer: directed vector table, async-reset sequence, then
// random traffic scored against a loop-semantics reference model.
module tb_hwlp_sequencer;
  localparam int N = 2;
  localparam int W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hwlp_if #(.N_HWLP_W(W)) bus ();
  logic [N-1:0][31:0] start_o, end_o, cnt_o;
  logic               active_o;
  logic               state_o;
`ifdef HWLP_SETUP_CHECK_EN
  logic               setup_err_o;
`endif

  hwlp_sequencer #(.N_HWLP(N), .N_HWLP_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .hwlp_start_o  (start_o),
    .hwlp_end_o    (end_o),
    .hwlp_cnt_o    (cnt_o),
    .hwlp_active_o (active_o),
    .state_dbg_o   (state_o)
`ifdef HWLP_SETUP_CHECK_EN
    , .setup_err_o (setup_err_o)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  we;
    logic        regid;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        e_jump;
    logic [31:0] e_target;
    logic [31:0] e_start0;
    logic [31:0] e_cnt0;
    logic [31:0] e_cnt1;
    logic        e_active;
  } vec_t;
  vec_t tbl[24];

  // Reference model state
  logic [31:0] m_start[N];
  logic [31:0] m_end[N];
  logic [31:0] m_cnt[N];
  logic        m_active;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] we, input logic regid, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic valid, input logic flush);
    bus.hwlp_we    = we;
    bus.hwlp_regid = regid;
    bus.hwlp_wdata = wdata;
    bus.pc_id      = pc;
    bus.id_valid   = valid;
    bus.flush      = flush;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_start[i] = 32'h0;
      m_end[i]   = 32'h0;
      m_cnt[i]   = 32'h0;
    end
    m_active = 1'b0;
  endtask

  // Innermost loop still iterating captures the PC; a loop on its final pass
  // just retires and leaves the PC to the enclosing loops.
  task automatic model_step(input logic [2:0] we, input int r, input logic [31:0] wd,
                            input logic [31:0] pc, input logic valid, input logic flush,
                            output logic ej, output logic [31:0] et);
    logic taken;
    taken = 1'b0;
    ej = 1'b0;
    et = 32'h0;
    for (int i = 0; i < N; i++) begin
      if (!taken && valid && !flush && m_cnt[i] != 0 && pc == m_end[i]) begin
        if (m_cnt[i] > 1) begin
          ej = 1'b1;
          et = m_start[i];
          taken = 1'b1;
        end
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
    if (we[0]) m_start[r] = wd & ~32'h1;
    if (we[1]) m_end[r]   = wd & ~32'h1;
    if (we[2]) m_cnt[r]   = wd;
    m_active = 1'b0;
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) m_active = 1'b1;
  endtask

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    tbl[0]  = '{3'b001, 1'b0, 32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h100, 32'd0, 32'd0, 1'b0};
    tbl[1]  = '{3'b010, 1'b0, 32'h10C, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h100, 32'd0, 32'd0, 1'b0};
    tbl[2]  = '{3'b100, 1'b0, 32'd3,   32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h100, 32'd3, 32'd0, 1'b1};
    tbl[3]  = '{3'b000, 1'b0, 32'h0,   32'h10C, 1'b1, 1'b0, 1'b1, 32'h100, 32'h100, 32'd2, 32'd0, 1'b1};
    tbl[4]  = '{3'b000, 1'b0, 32'h0,   32'h10C, 1'b1, 1'b0, 1'b1, 32'h100, 32'h100, 32'd1, 32'd0, 1'b1};
    tbl[5]  = '{3'b000, 1'b0, 32'h0,   32'h10C, 1'b1, 1'b0, 1'b0, 32'h0,   32'h100, 32'd0, 32'd0, 1'b0};
    tbl[6]  = '{3'b001, 1'b0, 32'h105, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd0, 32'd0, 1'b0};
    tbl[7]  = '{3'b010, 1'b0, 32'h108, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd0, 32'd0, 1'b0};
    tbl[8]  = '{3'b100, 1'b0, 32'd2,   32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd2, 32'd0, 1'b1};
    tbl[9]  = '{3'b001, 1'b1, 32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd2, 32'd0, 1'b1};
    tbl[10] = '{3'b010, 1'b1, 32'h108, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd2, 32'd0, 1'b1};
    tbl[11] = '{3'b100, 1'b1, 32'd2,   32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd2, 32'd2, 1'b1};
    tbl[12] = '{3'b000, 1'b0, 32'h0,   32'h108, 1'b1, 1'b0, 1'b1, 32'h104, 32'h104, 32'd1, 32'd2, 1'b1};
    tbl[13] = '{3'b000, 1'b0, 32'h0,   32'h108, 1'b1, 1'b0, 1'b1, 32'h100, 32'h104, 32'd0, 32'd1, 1'b1};
    tbl[14] = '{3'b000, 1'b0, 32'h0,   32'h108, 1'b1, 1'b0, 1'b0, 32'h0,   32'h104, 32'd0, 32'd0, 1'b0};
    tbl[15] = '{3'b100, 1'b0, 32'd5,   32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd5, 32'd0, 1'b1};
    tbl[16] = '{3'b000, 1'b0, 32'h0,   32'h108, 1'b1, 1'b1, 1'b0, 32'h0,   32'h104, 32'd5, 32'd0, 1'b1};
    tbl[17] = '{3'b000, 1'b0, 32'h0,   32'h108, 1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd5, 32'd0, 1'b1};
    tbl[18] = '{3'b100, 1'b0, 32'd4,   32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd4, 32'd0, 1'b1};
    tbl[19] = '{3'b100, 1'b0, 32'd9,   32'h108, 1'b1, 1'b0, 1'b1, 32'h104, 32'h104, 32'd9, 32'd0, 1'b1};
    tbl[20] = '{3'b100, 1'b0, 32'd0,   32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd0, 32'd0, 1'b0};
    tbl[21] = '{3'b000, 1'b0, 32'h0,   32'h108, 1'b1, 1'b0, 1'b0, 32'h0,   32'h104, 32'd0, 32'd0, 1'b0};
    tbl[22] = '{3'b100, 1'b0, 32'd3,   32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'd3, 32'd0, 1'b1};
    tbl[23] = '{3'b010, 1'b0, 32'h108, 32'h108, 1'b1, 1'b0, 1'b1, 32'h104, 32'h104, 32'd2, 32'd0, 1'b1};

    // Reset state
    drive(3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_cnt0", cnt_o[0], 32'h0);
    check("rst_start0", start_o[0], 32'h0);
    check("rst_end1", end_o[1], 32'h0);
    check("rst_active", {31'h0, active_o}, 32'h0);
    check("rst_jump", {31'h0, bus.hwlp_jump}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int k = 0; k < 24; k++) begin
      drive(tbl[k].we, tbl[k].regid, tbl[k].wdata, tbl[k].pc, tbl[k].valid, tbl[k].flush);
      #1;
      check($sformatf("vec%0d_jump", k), {31'h0, bus.hwlp_jump}, {31'h0, tbl[k].e_jump});
      if (tbl[k].e_jump)
        check($sformatf("vec%0d_target", k), bus.hwlp_target, tbl[k].e_target);
      else
        check($sformatf("vec%0d_target_idle", k), bus.hwlp_target, 32'h0);
      @(negedge clk);
      check($sformatf("vec%0d_start0", k), start_o[0], tbl[k].e_start0);
      check($sformatf("vec%0d_cnt0", k), cnt_o[0], tbl[k].e_cnt0);
      check($sformatf("vec%0d_cnt1", k), cnt_o[1], tbl[k].e_cnt1);
      check($sformatf("vec%0d_active", k), {31'h0, active_o}, {31'h0, tbl[k].e_active});
    end

    // Async reset in the middle of a running loop
    drive(3'b100, 1'b0, 32'd7, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("arst_pre_cnt0", cnt_o[0], 32'd7);
    drive(3'b000, 1'b0, 32'h0, 32'h108, 1'b1, 1'b0);
    #1;
    check("arst_pre_jump", {31'h0, bus.hwlp_jump}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_cnt0", cnt_o[0], 32'h0);
    check("arst_start0", start_o[0], 32'h0);
    check("arst_end0", end_o[0], 32'h0);
    check("arst_active", {31'h0, active_o}, 32'h0);
    check("arst_jump", {31'h0, bus.hwlp_jump}, 32'h0);
    check("arst_target", bus.hwlp_target, 32'h0);
    drive(3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef HWLP_SETUP_CHECK_EN
    // Malformed setup: end below start, then a non-zero count
    drive(3'b001, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(3'b010, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("serr_before", {31'h0, setup_err_o}, 32'h0);
    drive(3'b100, 1'b0, 32'd1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("serr_pulse", {31'h0, setup_err_o}, 32'h1);
    @(negedge clk);
    check("serr_clear", {31'h0, setup_err_o}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // Random traffic against the reference model
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  we;
      logic        rid;
      logic [31:0] wd, pc;
      logic        vld, fl, ej;
      logic [31:0] et;
      logic [32:0] exp_v;
      we  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rid = 1'($urandom_range(0, 1));
      if (we[2]) wd = 32'($urandom_range(0, 4));
      else       wd = 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 1));
      pc  = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      vld = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      model_step(we, int'(rid), wd, pc, vld, fl, ej, et);
      exp_q.push_back({ej, et});
      drive(we, rid, wd, pc, vld, fl);
      #1;
      exp_v = exp_q.pop_front();
      check("rnd_jump", {31'h0, bus.hwlp_jump}, {31'h0, exp_v[32]});
      check("rnd_target", bus.hwlp_target, exp_v[32] ? exp_v[31:0] : 32'h0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        check($sformatf("rnd_start%0d", i), start_o[i], m_start[i]);
        check($sformatf("rnd_end%0d", i), end_o[i], m_end[i]);
        check($sformatf("rnd_cnt%0d", i), cnt_o[i], m_cnt[i]);
      end
      check("rnd_active", {31'h0, active_o}, {31'h0, m_active});
      check("rnd_state", {31'h0, state_o}, {31'h0, m_active});
    end

    drive(3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
